// File: rtl/hdlc_pkg.sv
// hdlc_pkg: shared definitions for the HDLC transmit sequencer.
//  - register bus addresses of the HDLC core
//  - bit positions inside the Tx_SC status/control register
//  - command bytes the sequencer writes to Tx_SC
//  - sequencer state encoding
package hdlc_pkg;

  // Register bus addresses
  localparam logic [2:0] TX_SC   = 3'h0;
  localparam logic [2:0] TX_BUFF = 3'h1;
  localparam logic [2:0] RX_SC   = 3'h2;
  localparam logic [2:0] RX_BUFF = 3'h3;
  localparam logic [2:0] RX_LEN  = 3'h4;

  // Tx_SC bit indices
  localparam int SC_DONE         = 0;
  localparam int SC_ENABLE       = 1;
  localparam int SC_ABORTFRAME   = 2;
  localparam int SC_ABORTEDTRANS = 3;
  localparam int SC_FULL         = 4;

  // One-hot Tx_SC command byte for a given bit index
  function automatic logic [7:0] sc_bit(input int idx);
    sc_bit = 8'h01 << idx;
  endfunction

  localparam logic [7:0] SC_CMD_ENABLE = sc_bit(SC_ENABLE);      // 8'h02
  localparam logic [7:0] SC_CMD_ABORT  = sc_bit(SC_ABORTFRAME);  // 8'h04

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    LOAD,
    DROP,
    START,
    POLL,
    ABORT
  } tx_seq_state_t;

endpackage

// File: rtl/hdlc_reg_bus_if.sv
// hdlc_reg_bus_if: HDLC 3-bit register bus.
//  Address/WriteEnable/ReadEnable/DataIn travel master -> slave,
//  DataOut travels slave -> master and is valid the cycle after ReadEnable.
interface hdlc_reg_bus_if;
  logic [2:0] Address;
  logic       WriteEnable;
  logic       ReadEnable;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  modport master (output Address, WriteEnable, ReadEnable, DataIn, input DataOut);
  modport slave  (input Address, WriteEnable, ReadEnable, DataIn, output DataOut);
endinterface

// File: rtl/hdlc_bus_arbiter.sv
// hdlc_bus_arbiter: shares the register bus between the sequencer FSM and a host.
//  clk, rst      clock / asynchronous active-high reset
//  idle          sequencer is in IDLE; the host may only be granted then
//  host_req      host asks for the bus
//  host_gnt      host owns the bus (registered, held while host_req stays high)
//  fsm_*         bus access requested by the sequencer FSM
//  host          host side of the bus (host is the master, we are its slave)
//  bus           register bus towards the HDLC core
module hdlc_bus_arbiter
  import hdlc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 idle,
  input  logic                 host_req,
  output logic                 host_gnt,
  input  logic [2:0]           fsm_addr,
  input  logic                 fsm_we,
  input  logic                 fsm_re,
  input  logic [7:0]           fsm_data,
  hdlc_reg_bus_if.slave        host,
  hdlc_reg_bus_if.master       bus
);

  // Grant register: granted only from IDLE, then held until the host lets go
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      host_gnt <= 1'b0;
    end else begin
      host_gnt <= host_req && (host_gnt || idle);
    end
  end

  // Bus mux: host drives the bus combinationally while granted
  always_comb begin
    host.DataOut = bus.DataOut;
    if (host_gnt) begin
      bus.Address     = host.Address;
      bus.WriteEnable = host.WriteEnable;
      bus.ReadEnable  = host.ReadEnable;
      bus.DataIn      = host.DataIn;
    end else begin
      bus.Address     = fsm_addr;
      bus.WriteEnable = fsm_we;
      bus.ReadEnable  = fsm_re;
      bus.DataIn      = fsm_data;
    end
  end

endmodule

// File: rtl/hdlc_tx_sequencer.sv
// hdlc_tx_sequencer: register-bus master that pushes one frame into the HDLC
// transmitter.
//  clk, rst                  clock / asynchronous active-high reset
//  s_valid/s_ready/s_data/s_last  frame byte stream in
//  abort_req                 one-cycle pulse, aborts the frame in CHECK/LOAD/POLL
//  busy                      high outside IDLE
//  done/aborted/overflow_err one-cycle result pulses (mutually exclusive)
//  host_req/host_gnt         host bus request / grant (granted only in IDLE)
//  host                      host register bus port
//  bus                       register bus to the HDLC core
// Flow: IDLE -> CHECK (wait for Tx_Done) -> LOAD (write Tx_Buff) -> START
// (Tx_Enable) -> POLL (wait for Tx_Done / Tx_AbortedTrans) -> IDLE.
// Frames longer than MAX_BYTES go through DROP, which flushes with Tx_AbortFrame.
module hdlc_tx_sequencer
  import hdlc_pkg::*;
#(
  parameter int MAX_BYTES     = 126,
  parameter int POLL_INTERVAL = 16
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [7:0]     s_data,
  input  logic           s_last,
  input  logic           abort_req,
  output logic           busy,
  output logic           done,
  output logic           aborted,
  output logic           overflow_err,
  input  logic           host_req,
  output logic           host_gnt,
  hdlc_reg_bus_if.slave  host,
  hdlc_reg_bus_if.master bus
);

  localparam int             TW       = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0]  TMR_LAST = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]     CNT_LAST = 8'(MAX_BYTES - 1);

  tx_seq_state_t state_r, state_next_s;
  logic [7:0]    cnt_r;
  logic [TW-1:0] tmr_r;
  logic          rd_pending_r;   // a Tx_SC read was issued last cycle; DataOut is valid now
  logic          flush_r;        // DROP has swallowed s_last; issue the flush write

  logic [2:0]    fsm_addr_s;
  logic          fsm_we_s;
  logic          fsm_re_s;
  logic [7:0]    fsm_data_s;
  logic          byte_acc_s;
  logic          flush_set_s;
  logic          done_set_s;
  logic          aborted_set_s;
  logic          ovf_set_s;

  assign busy = (state_r != IDLE);

  // Next-state, bus request and handshake decode
  always_comb begin
    state_next_s  = state_r;
    fsm_addr_s    = TX_SC;
    fsm_we_s      = 1'b0;
    fsm_re_s      = 1'b0;
    fsm_data_s    = 8'h00;
    s_ready       = 1'b0;
    byte_acc_s    = 1'b0;
    flush_set_s   = 1'b0;
    done_set_s    = 1'b0;
    aborted_set_s = 1'b0;
    ovf_set_s     = 1'b0;
    case (state_r)
      IDLE: begin
        // host_req blocks the start so a simultaneous request wins
        if (s_valid && !host_gnt && !host_req) begin
          state_next_s = CHECK;
        end else begin
          state_next_s = IDLE;
        end
      end
      CHECK: begin
        if (abort_req) begin
          state_next_s = ABORT;
        end else if (rd_pending_r) begin
          if (bus.DataOut[SC_DONE]) begin
            state_next_s = LOAD;
          end else begin
            state_next_s = CHECK;
          end
        end else if (tmr_r == TMR_LAST) begin
          fsm_re_s = 1'b1;
        end else begin
          state_next_s = CHECK;
        end
      end
      LOAD: begin
        // abort beats a same-cycle byte: s_ready stays low
        if (abort_req) begin
          state_next_s = ABORT;
        end else begin
          s_ready = 1'b1;
          if (s_valid) begin
            fsm_we_s   = 1'b1;
            fsm_addr_s = TX_BUFF;
            fsm_data_s = s_data;
            byte_acc_s = 1'b1;
            if (s_last) begin
              state_next_s = START;
            end else if (cnt_r == CNT_LAST) begin
              // buffer now holds MAX_BYTES and more are coming
              state_next_s = DROP;
            end else begin
              state_next_s = LOAD;
            end
          end else begin
            state_next_s = LOAD;
          end
        end
      end
      DROP: begin
        if (flush_r) begin
          fsm_we_s     = 1'b1;
          fsm_data_s   = SC_CMD_ABORT;
          ovf_set_s    = 1'b1;
          state_next_s = IDLE;
        end else begin
          s_ready = 1'b1;
          if (s_valid && s_last) begin
            flush_set_s = 1'b1;
          end else begin
            flush_set_s = 1'b0;
          end
        end
      end
      START: begin
        fsm_we_s     = 1'b1;
        fsm_data_s   = SC_CMD_ENABLE;
        state_next_s = POLL;
      end
      POLL: begin
        if (abort_req) begin
          state_next_s = ABORT;
        end else if (rd_pending_r) begin
          if (bus.DataOut[SC_ABORTEDTRANS]) begin
            aborted_set_s = 1'b1;
            state_next_s  = IDLE;
          end else if (bus.DataOut[SC_DONE]) begin
            done_set_s   = 1'b1;
            state_next_s = IDLE;
          end else begin
            state_next_s = POLL;
          end
        end else if (tmr_r == TMR_LAST) begin
          fsm_re_s = 1'b1;
        end else begin
          state_next_s = POLL;
        end
      end
      ABORT: begin
        fsm_we_s      = 1'b1;
        fsm_data_s    = SC_CMD_ABORT;
        aborted_set_s = 1'b1;
        state_next_s  = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, counters and result pulse registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= 8'd0;
      tmr_r        <= '0;
      rd_pending_r <= 1'b0;
      flush_r      <= 1'b0;
      done         <= 1'b0;
      aborted      <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      rd_pending_r <= fsm_re_s;
      flush_r      <= flush_set_s;
      done         <= done_set_s;
      aborted      <= aborted_set_s;
      overflow_err <= ovf_set_s;

      if (state_r == IDLE) begin
        cnt_r <= 8'd0;
      end else if (byte_acc_s) begin
        cnt_r <= cnt_r + 8'd1;
      end

      // Preload on entry so the first status read happens immediately;
      // afterwards reads are POLL_INTERVAL cycles apart.
      if ((state_next_s == CHECK || state_next_s == POLL) && (state_next_s != state_r)) begin
        tmr_r <= TMR_LAST;
      end else if (fsm_re_s) begin
        tmr_r <= '0;
      end else if (tmr_r != TMR_LAST) begin
        tmr_r <= tmr_r + TW'(1);
      end
    end
  end

  hdlc_bus_arbiter u_arb (
    .clk      (clk),
    .rst      (rst),
    .idle     (state_r == IDLE),
    .host_req (host_req),
    .host_gnt (host_gnt),
    .fsm_addr (fsm_addr_s),
    .fsm_we   (fsm_we_s),
    .fsm_re   (fsm_re_s),
    .fsm_data (fsm_data_s),
    .host     (host),
    .bus      (bus)
  );

endmodule
